// File: rtl/mem_bus_pkg.sv
// Shared constants for the instruction/data memory bus arbiter.
// State codes, grant indices and the slave request bundle live here.
package mem_bus_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  localparam logic G_I = 1'b0;
  localparam logic G_D = 1'b1;

  localparam int TIMEOUT_DEF = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } sreq_t;

  function automatic logic [1:0] gnt_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts strobe cycles that go unanswered by the slave and flags expiry
// combinationally on the cycle the count reaches TIMEOUT-1.
module bus_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            clear;

  assign clear  = ~active | ~stb | ack | err;
  assign expire = ~clear & (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter for a single
// Wishbone-style memory slave, with a per-transfer timeout watchdog.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int PRIORITY = 0,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int TO_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr_i,
  input  logic        icyc_i,
  input  logic        istb_i,
  output logic [31:0] idat_o,
  output logic        iack_o,
  output logic        ierr_o,
  input  logic [31:0] daddr_i,
  input  logic [31:0] ddat_i,
  input  logic [3:0]  dsel_i,
  input  logic        dwe_i,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  output logic [31:0] ddat_o,
  output logic        dack_o,
  output logic        derr_o,
  output logic [31:0] saddr_o,
  output logic [31:0] sdat_o,
  output logic [3:0]  ssel_o,
  output logic        swe_o,
  output logic        scyc_o,
  output logic        sstb_o,
  input  logic [31:0] sdat_i,
  input  logic        sack_i,
  input  logic        serr_i,
  output logic [1:0]  gnt_o
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;

  logic  own_is_d, sel_i, sel_d, in_grant;
  logic  g_cyc, g_stb, expire;
  sreq_t i_req, d_req, s_req;

  // Owner comes from the registered grant so it stays valid through ABORT.
  assign own_is_d = gnt_q[G_D];
  assign sel_i    = (state_q == GNT_I);
  assign sel_d    = (state_q == GNT_D);
  assign in_grant = sel_i | sel_d;
  assign g_cyc    = own_is_d ? dcyc_i : icyc_i;
  assign g_stb    = own_is_d ? dstb_i : istb_i;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .active(in_grant),
    .stb   (g_stb),
    .ack   (sack_i),
    .err   (serr_i),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (icyc_i && dcyc_i) begin
          if (PRIORITY == 1 || last_q == G_I) begin
            state_d = GNT_D;
            gnt_d   = gnt_onehot(G_D);
          end else begin
            state_d = GNT_I;
            gnt_d   = gnt_onehot(G_I);
          end
        end else if (dcyc_i) begin
          state_d = GNT_D;
          gnt_d   = gnt_onehot(G_D);
        end else if (icyc_i) begin
          state_d = GNT_I;
          gnt_d   = gnt_onehot(G_I);
        end
      end
      GNT_I, GNT_D: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = own_is_d;
          gnt_d   = 2'b00;
        end else if (expire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = own_is_d;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= G_I;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Instruction fetches are always full-word reads.
  assign i_req = '{addr: iaddr_i, dat: 32'h0, sel: 4'hF, we: 1'b0};
  assign d_req = '{addr: daddr_i, dat: ddat_i, sel: dsel_i, we: dwe_i};

  always_comb begin
    s_req = '0;
    if (sel_i) s_req = i_req;
    if (sel_d) s_req = d_req;
  end

  assign saddr_o = s_req.addr;
  assign sdat_o  = s_req.dat;
  assign ssel_o  = s_req.sel;
  assign swe_o   = s_req.we;

  assign scyc_o = in_grant & g_cyc & ~expire;
  assign sstb_o = in_grant & g_stb & ~expire;

  assign iack_o = sel_i & sack_i;
  assign ierr_o = sel_i & (serr_i | expire);
  assign idat_o = sel_i ? sdat_i : 32'h0;

  assign dack_o = sel_d & sack_i;
  assign derr_o = sel_d & (serr_i | expire);
  assign ddat_o = sel_d ? sdat_i : 32'h0;

  assign gnt_o = gnt_q;

endmodule
